fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit period; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_en  input  1  permits starting a new frame; has no effect on a frame already in progress.
REQ-005 SHALL have port fifo_empty  input  1  empty flag from the FIFO read side.
REQ-006 SHALL have port fifo_rd_data  input  8  FIFO read data, valid one clk cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  one-cycle pop request to the FIFO.
REQ-008 SHALL have port tx  output  1  UART serial line: idle high, 8N1, LSB first.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, START, DATA, STOP.
REQ-011 IDLE: when tx_en=1 and fifo_empty=0, SHALL assert fifo_rd_en for exactly that cycle and go to FETCH; otherwise SHALL hold fifo_rd_en=0.
REQ-012 FETCH: SHALL load fifo_rd_data into an 8-bit shift register and go to START; fifo_rd_en=0.
REQ-013 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-014 DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state change, and wrap without overflow; width SHALL be $clog2(CLKS_PER_BIT).
REQ-017 Bit counter SHALL be 3 bits, 0..7, and clear on entry to DATA.
REQ-018 tx SHALL be driven from a register, with no combinational glitches.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-020 Back-to-back frames: with the FIFO non-empty, the gap between the end of STOP and the next START SHALL be exactly 2 cycles (IDLE, FETCH) with tx=1.
REQ-021 fifo_rd_en SHALL never assert when fifo_empty=0 was not sampled in the same cycle; at most one pop per frame.
REQ-022 Changes to fifo_empty or tx_en during FETCH..STOP SHALL not alter the current frame.
REQ-023 tx_en falling in IDLE SHALL prevent any pop; no data SHALL be lost.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, tx=1, fifo_rd_en=0, busy=0, baud and bit counters=0, and shift_reg=8'h00.
REQ-025 Reset mid-frame SHALL abort the frame; the popped byte is discarded, and tx returns high asynchronously.
REQ-026 After rst deasserts, the first pop SHALL occur no earlier than the first clk edge with rst=0.

Structure
REQ-027 State encoding, the 8N1 frame constants (DATA_BITS=8, FRAME_BITS=10) and the default CLKS_PER_BIT SHALL live in shared package uart_pkg.
REQ-028 The baud counter SHALL be a sub-module uart_baud_cnt (clk, rst, clr, tick), where tick is high on count CLKS_PER_BIT-1.
REQ-029 The block SHALL connect to the async FIFO read-side ports (rd_clk=clk, rd_rst=rst, rd_en, rd_data, o_fifo_empty) without glue logic.

Verification (CLKS_PER_BIT=4)
REQ-030 FIFO holds 0xA5, tx_en=1 -> one fifo_rd_en pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
REQ-031 fifo_empty=1 for 100 cycles, tx_en=1 -> fifo_rd_en never asserts, tx=1, busy=0.
REQ-032 FIFO holds 0x00 then 0xFF -> two frames separated by exactly 2 idle-high cycles; exactly 2 pops.
REQ-033 rst asserted at cycle 15 of a frame -> tx=1 and busy=0 before the next clk edge; the next frame starts with a fresh pop.
REQ-034 tx_en dropped during DATA -> current frame completes; no further pop until tx_en=1 again.
REQ-035 fifo_empty toggling every cycle during a frame -> frame bits unchanged; no extra fifo_rd_en pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: frame constants, default bit period and TX state encoding.
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int FRAME_BITS           = 10;
   localparam int CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and pulses tick on the last count of each period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops one byte per frame from a FIFO read port.
// tx and busy are registered from the next state so the serial line never glitches.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy
);

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       rd_en_c;
   logic       baud_clr;
   logic       baud_tick;

   assign baud_clr = (state_d != state_q);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .tick (baud_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      rd_en_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tx_en && !fifo_empty) begin
               rd_en_c = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            shift_d = fifo_rd_data;
            state_d = START;
         end
         START: begin
            if (baud_tick) begin
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is decided for the cycle about to start, then registered.
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign fifo_rd_en = rd_en_c & ~rst;
   assign tx         = tx_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_en;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;

   logic [7:0] mem [0:15];
   int         wr_ptr   = 0;
   int         rd_ptr   = 0;
   int         pop_cnt  = 0;
   logic       tgl_mode = 1'b0;
   logic       tgl_val  = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign fifo_empty = tgl_mode ? tgl_val : (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr[3:0]];
         rd_ptr       <= rd_ptr + 1;
         pop_cnt      <= pop_cnt + 1;
      end
   end

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .tx           (tx),
      .busy         (busy)
   );

   // Each frame bit (bit 0 = start) held for CPB samples.
   function automatic logic [39:0] expand(input logic [9:0] f);
      logic [39:0] e;
      for (int i = 0; i < 40; i++) e[i] = f[i / CPB];
      return e;
   endfunction

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[3:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_start(output int gap);
      bit found;
      found = 1'b0;
      gap   = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
         else gap++;
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL start_timeout: tx never went low within 300 cycles (got tx=%b, need 0)", tx);
      end
   endtask

   task automatic capture(input int drop_at, input bit toggle, output logic [39:0] got);
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         got[i] = tx;
         if (i == drop_at) tx_en = 1'b0;
         if (toggle) begin
            tgl_mode = (i < 30);
            tgl_val  = ~tgl_val;
         end
      end
   endtask

   task automatic check_frame(input string name, input logic [39:0] got, input logic [9:0] f);
      n_checks++;
      if (got !== expand(f)) begin
         n_errors++;
         $display("FAIL %s: got %h, need %h", name, got, expand(f));
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      tx_en = 1'b1;
      push(8'hA5);
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b, need 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, need 0", busy); end
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en: got %b, need 0", fifo_rd_en); end
      n_checks++;
      if (pop_cnt !== 0) begin n_errors++; $display("FAIL reset_pops: got %0d, need 0", pop_cnt); end
      tx_en = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_a5;
      int p0, gap;
      logic [39:0] got;
      p0    = pop_cnt;
      tx_en = 1'b1;
      wait_start(gap);
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL a5_busy: got %b, need 1", busy); end
      capture(-1, 1'b0, got);
      check_frame("a5_frame", got, 10'b1101001010);
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_errors++; $display("FAIL a5_idle_tx: got %b, need 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL a5_idle_busy: got %b, need 0", busy); end
      n_checks++;
      if (pop_cnt - p0 !== 1) begin n_errors++; $display("FAIL a5_pops: got %0d, need 1", pop_cnt - p0); end
   endtask

   task automatic test_empty;
      int p0, bad_rd, bad_tx, bad_busy;
      p0 = pop_cnt; bad_rd = 0; bad_tx = 0; bad_busy = 0;
      tx_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0) bad_rd++;
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
      end
      n_checks++;
      if (bad_rd !== 0) begin n_errors++; $display("FAIL empty_rd_en: got %0d high cycles, need 0", bad_rd); end
      n_checks++;
      if (bad_tx !== 0) begin n_errors++; $display("FAIL empty_tx: got %0d low cycles, need 0", bad_tx); end
      n_checks++;
      if (bad_busy !== 0) begin n_errors++; $display("FAIL empty_busy: got %0d busy cycles, need 0", bad_busy); end
      n_checks++;
      if (pop_cnt - p0 !== 0) begin n_errors++; $display("FAIL empty_pops: got %0d, need 0", pop_cnt - p0); end
   endtask

   task automatic test_back_to_back;
      int p0, gap;
      logic [39:0] got;
      p0 = pop_cnt;
      push(8'h00);
      push(8'hFF);
      wait_start(gap);
      capture(-1, 1'b0, got);
      check_frame("b2b_frame0", got, 10'b1000000000);
      wait_start(gap);
      n_checks++;
      if (gap !== 2) begin n_errors++; $display("FAIL b2b_gap: got %0d cycles, need 2", gap); end
      capture(-1, 1'b0, got);
      check_frame("b2b_frame1", got, 10'b1111111110);
      repeat (5) @(negedge clk);
      n_checks++;
      if (pop_cnt - p0 !== 2) begin n_errors++; $display("FAIL b2b_pops: got %0d, need 2", pop_cnt - p0); end
   endtask

   task automatic test_reset_mid;
      int p0, gap;
      logic [39:0] got;
      p0 = pop_cnt;
      push(8'h5A);
      wait_start(gap);
      repeat (15) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_errors++; $display("FAIL rstmid_tx: got %b, need 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b, need 0", busy); end
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin n_errors++; $display("FAIL rstmid_rd_en: got %b, need 0", fifo_rd_en); end
      @(negedge clk);
      rst = 1'b0;
      push(8'hC3);
      wait_start(gap);
      capture(-1, 1'b0, got);
      check_frame("rstmid_frame", got, 10'b1110000110);
      n_checks++;
      if (pop_cnt - p0 !== 2) begin n_errors++; $display("FAIL rstmid_pops: got %0d, need 2", pop_cnt - p0); end
   endtask

   task automatic test_txen_drop;
      int p0, gap;
      logic [39:0] got;
      p0 = pop_cnt;
      push(8'h81);
      push(8'h42);
      wait_start(gap);
      capture(12, 1'b0, got);
      check_frame("drop_frame", got, 10'b1100000010);
      repeat (20) @(negedge clk);
      n_checks++;
      if (pop_cnt - p0 !== 1) begin n_errors++; $display("FAIL drop_pops_held: got %0d, need 1", pop_cnt - p0); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL drop_busy: got %b, need 0", busy); end
      tx_en = 1'b1;
      wait_start(gap);
      capture(-1, 1'b0, got);
      check_frame("drop_resume_frame", got, 10'b1010000100);
      n_checks++;
      if (pop_cnt - p0 !== 2) begin n_errors++; $display("FAIL drop_pops_total: got %0d, need 2", pop_cnt - p0); end
   endtask

   task automatic test_empty_toggle;
      int p0, gap;
      logic [39:0] got;
      p0 = pop_cnt;
      tx_en = 1'b1;
      push(8'h3C);
      wait_start(gap);
      capture(-1, 1'b1, got);
      tgl_mode = 1'b0;
      check_frame("toggle_frame", got, 10'b1001111000);
      repeat (5) @(negedge clk);
      n_checks++;
      if (pop_cnt - p0 !== 1) begin n_errors++; $display("FAIL toggle_pops: got %0d, need 1", pop_cnt - p0); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL toggle_busy: got %b, need 0", busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      tx_en = 1'b0;
      test_reset;
      test_single_a5;
      test_empty;
      test_back_to_back;
      test_reset_mid;
      test_txen_drop;
      test_empty_toggle;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
